uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Parametrised receive FIFO for the UART16550 core, the successor to the fixed 16-entry receive buffer. It sits between the receive shift engine and the APB4 register file. Each entry stores a character plus its break, framing and parity flags. Depth and data width are generic. It also provides:
- a programmable trigger level
- overrun detection
- the aggregate receive FIFO error bit (LSR[7])
- the four-character-time timeout indication
- 16450 (non-FIFO, single-entry) mode

## Interface
- DEPTH, 16, number of entries; power of 2, ≥4
- DATA_WIDTH, 8, character width
- PCLK  in  1  clock
- PRESETn  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush (FCR rx_rst)
- ena  in  1  FIFO mode enable; 0 = 16450 mode with capacity 1
- trigger_lvl  in  2  rx trigger select: 00/01/10/11 → 1, DEPTH/4, DEPTH/2, DEPTH-2
- char_tick  in  1  one-cycle pulse per received character time
- push  in  1  write strobe from receiver
- push_d  in  DATA_WIDTH+3  {bi, fe, pe, d}
- pop  in  1  read strobe (RBR read)
- pop_d  out  DATA_WIDTH+3  head entry, show-ahead; all zeros when empty
- empty  out  1  no entries
- full  out  1  level == capacity
- level  out  $clog2(DEPTH)+1  current entry count
- overrun  out  1  one-cycle pulse on push while full
- trigger  out  1  level ≥ selected threshold
- timeout  out  1  character timeout indication
- error  out  1  at least one stored entry has bi|fe|pe set

## Operation
- Storage: circular buffer with read/write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH. The memory array is not reset.
- Capacity is DEPTH when ena=1 and 1 when ena=0.
- Flush (clears level, pointers, error count and timeout count) happens when either:
  - clr=1, or
  - ena differs from its registered copy ena_q (i.e. any FIFO-mode change).
- Flush has priority over push and pop in the same cycle. A push during a flush is discarded and does not pulse overrun.
- Push, not full: the entry is written at wptr, wptr++, level++.
- Push, full, ena=1:
  - if pop is also asserted: both happen, level unchanged, no overrun;
  - otherwise: data is dropped, contents are unchanged, overrun pulses.
- Push, full, ena=0: the single entry is overwritten, level stays 1, overrun pulses. This holds even if pop is asserted in the same cycle.
- Pop, not empty: rptr++, level--. Pop while empty is ignored.
- Push and pop together while empty: the push is accepted and the pop is ignored.
- Error count has width $clog2(DEPTH)+1.
  - +1 on an accepted push whose flags are nonzero.
  - −1 on a pop whose head flags are nonzero.
  - On a 16450-mode overwrite, the count is recomputed from the new entry's flags.
  - error = (count ≠ 0).
- Timeout counter is 3 bits and saturates at 4.
  - Cleared on push, pop, flush, or while empty.
  - Incremented on char_tick otherwise.
  - timeout = (count == 4) & ~empty & ena.
- Trigger:
  - ena=1: trigger = level ≥ threshold(trigger_lvl).
  - ena=0: trigger = ~empty.

## Timing
- Reset values: empty=1, full=0, level=0, overrun=0, trigger=0, timeout=0, error=0, pop_d=0. Pointers, counters and ena_q reset to 0.
- All state updates on the rising PCLK edge. level, empty, full, trigger and error reflect a push or pop on the cycle after it.
- pop_d is a combinational read of mem[rptr] gated by ~empty. New head data is visible the cycle after a pop.
- overrun is registered and high for exactly the one cycle following the offending push.
- An ena change takes effect as a flush at the edge where ena ≠ ena_q, i.e. one cycle after ena changes.
- timeout rises on the cycle after the 4th qualifying char_tick and falls on the cycle after the clearing push or pop.
- PRESETn assertion mid-operation immediately forces all outputs to their reset values, independent of PCLK.

## Test plan
- Reset and basic fill, DEPTH=16, ena=1: push 16 entries 0x00..0x0F → full=1, level=16; 16 pops return 0x00..0x0F in order; empty=1.
- Overrun: a full FIFO plus a 17th push of 0xAA → overrun pulses 1 cycle, level stays 16, head still 0x00. Repeat with simultaneous pop → no overrun, 0xAA lands at the tail.
- Trigger and wrap: trigger_lvl=10 → trigger rises when level reaches 8. Sustained push/pop for 40 characters → data order preserved across pointer wrap.
- Error tracking: push 0x41 with fe=1, then 0x42 clean → error=1. Pop once → error=0.
- Timeout: push 1 entry, issue 3 char_tick → timeout=0; 4th char_tick → timeout=1; pop → timeout=0 next cycle.
- 16450 mode and flush:
  - Set ena 1→0 with 5 entries stored → flushed next cycle.
  - Push 0x11 then 0x22 → overrun pulses, pop_d=0x22, level=1.
  - Assert clr together with a push → empty=1, no overrun.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: receiver/register-file handshake and status bundle for the UART receive FIFO
interface uart_rx_fifo_if #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8
);
   logic                         push;
   logic [DATA_WIDTH+2:0]        push_d;
   logic                         pop;
   logic [DATA_WIDTH+2:0]        pop_d;
   logic                         empty;
   logic                         full;
   logic [$clog2(DEPTH):0]       level;
   logic                         overrun;
   logic                         trigger;
   logic                         timeout;
   logic                         error;

   modport master (
      output push, push_d, pop,
      input  pop_d, empty, full, level, overrun, trigger, timeout, error
   );

   modport slave (
      input  push, push_d, pop,
      output pop_d, empty, full, level, overrun, trigger, timeout, error
   );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receive FIFO with trigger, overrun, error and timeout tracking
// Entries are {bi, fe, pe, d}; ena=0 collapses the FIFO to a single overwriteable 16450 holding register.
module uart_rx_fifo #(
   parameter int DEPTH      = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic          PCLK,
   input  logic          PRESETn,
   input  logic          clr,
   input  logic          ena,
   input  logic [1:0]    trigger_lvl,
   input  logic          char_tick,
   uart_rx_fifo_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int EW = DATA_WIDTH + 3;

   logic [EW-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [LW-1:0] cnt, err_cnt, cap, thr;
   logic [2:0]    to_cnt;
   logic          ena_q, ovr_q;
   logic          flush, is_empty, is_full, ow, wr, rd, in_flag, head_flag;
   logic [EW-1:0] head;

   always_comb begin
      flush     = clr | (ena ^ ena_q);
      cap       = ena ? LW'(DEPTH) : LW'(1);
      is_empty  = cnt == '0;
      is_full   = cnt == cap;
      head      = mem[rptr];
      head_flag = |head[EW-1:DATA_WIDTH];
      in_flag   = |bus.push_d[EW-1:DATA_WIDTH];
      ow        = bus.push & is_full & ~ena;
      wr        = bus.push & (~is_full | (ena & bus.pop));
      rd        = bus.pop & ~is_empty & ~ow;
      thr       = trigger_lvl == 2'd0 ? LW'(1) :
                  trigger_lvl == 2'd1 ? LW'(DEPTH/4) :
                  trigger_lvl == 2'd2 ? LW'(DEPTH/2) : LW'(DEPTH-2);
   end

   always_ff @(posedge PCLK or negedge PRESETn) begin
      if (!PRESETn) begin
         wptr    <= '0;
         rptr    <= '0;
         cnt     <= '0;
         err_cnt <= '0;
         to_cnt  <= '0;
         ena_q   <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ena_q <= ena;
         ovr_q <= ~flush & bus.push & is_full & ~(ena & bus.pop);
         if (flush) begin
            wptr    <= '0;
            rptr    <= '0;
            cnt     <= '0;
            err_cnt <= '0;
            to_cnt  <= '0;
         end else begin
            if (wr) wptr <= wptr + 1'b1;
            if (rd) rptr <= rptr + 1'b1;
            cnt     <= cnt + LW'(wr) - LW'(rd);
            // a 16450 overwrite replaces the only entry, so its flags alone define the count
            err_cnt <= ow ? LW'(in_flag) : err_cnt + LW'(wr & in_flag) - LW'(rd & head_flag);
            to_cnt  <= (bus.push | bus.pop | is_empty) ? 3'd0 :
                       (char_tick && to_cnt != 3'd4) ? to_cnt + 3'd1 : to_cnt;
         end
      end
   end

   always_ff @(posedge PCLK)
      if (!flush && (wr || ow)) mem[ow ? rptr : wptr] <= bus.push_d;

   assign bus.pop_d   = is_empty ? '0 : head;
   assign bus.empty   = is_empty;
   assign bus.full    = is_full;
   assign bus.level   = cnt;
   assign bus.overrun = ovr_q;
   assign bus.trigger = ena ? (cnt >= thr) : ~is_empty;
   assign bus.timeout = (to_cnt == 3'd4) & ~is_empty & ena;
   assign bus.error   = |err_cnt;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed plus randomized checks of uart_rx_fifo against a queue-based reference model
module tb_uart_rx_fifo;
   localparam int DEPTH = 16;
   localparam int DW    = 8;
   localparam int EW    = DW + 3;

   logic       PCLK = 1'b0;
   logic       PRESETn = 1'b0;
   logic       clr = 1'b0;
   logic       ena = 1'b1;
   logic [1:0] trigger_lvl = 2'd0;
   logic       char_tick = 1'b0;

   uart_rx_fifo_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) bus ();

   uart_rx_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
      .PCLK(PCLK), .PRESETn(PRESETn), .clr(clr), .ena(ena),
      .trigger_lvl(trigger_lvl), .char_tick(char_tick), .bus(bus)
   );

   always #5 PCLK = ~PCLK;

   int          compared = 0;
   int          mismatched = 0;
   logic [EW-1:0] q[$];
   int          tk = 0;
   logic        ena_qm = 1'b0;
   logic        ovr_m = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic int thr_of(input logic [1:0] l);
      return l == 2'd0 ? 1 : l == 2'd1 ? DEPTH/4 : l == 2'd2 ? DEPTH/2 : DEPTH-2;
   endfunction

   task automatic check_all(input string tag);
      int n;
      int e;
      n = q.size();
      e = 0;
      foreach (q[i]) if (q[i][EW-1:DW] != 3'b0) e = 1;
      chk({tag, ".level"},   32'(bus.level),   32'(n));
      chk({tag, ".empty"},   32'(bus.empty),   32'(n == 0));
      chk({tag, ".full"},    32'(bus.full),    32'(n == (ena ? DEPTH : 1)));
      chk({tag, ".pop_d"},   32'(bus.pop_d),   n != 0 ? 32'(q[0]) : 32'd0);
      chk({tag, ".error"},   32'(bus.error),   32'(e));
      chk({tag, ".trigger"}, 32'(bus.trigger), ena ? 32'(n >= thr_of(trigger_lvl)) : 32'(n != 0));
      chk({tag, ".timeout"}, 32'(bus.timeout), 32'(tk == 4 && n != 0 && ena));
      chk({tag, ".overrun"}, 32'(bus.overrun), 32'(ovr_m));
   endtask

   task automatic step(input string tag, input logic ps, input logic [EW-1:0] pd,
                       input logic pp, input logic tick, input logic cl);
      int  cap;
      bit  full_m, emp_m;
      bus.push = ps; bus.push_d = pd; bus.pop = pp; char_tick = tick; clr = cl;
      @(posedge PCLK);
      cap = ena ? DEPTH : 1;
      ovr_m = 1'b0;
      if (cl || ena !== ena_qm) begin
         q.delete();
         tk = 0;
      end else begin
         emp_m  = q.size() == 0;
         full_m = q.size() == cap;
         if (ps && full_m && !ena) begin
            q[0] = pd;
            ovr_m = 1'b1;
         end else if (ps && full_m && !pp) begin
            ovr_m = 1'b1;
         end else begin
            if (pp && !emp_m) void'(q.pop_front());
            if (ps) q.push_back(pd);
         end
         if (ps || pp || emp_m) tk = 0;
         else if (tick && tk < 4) tk++;
      end
      ena_qm = ena;
      #1;
      bus.push = 1'b0; bus.pop = 1'b0; char_tick = 1'b0; clr = 1'b0;
      check_all(tag);
   endtask

   task automatic push1(input string tag, input logic [EW-1:0] d); step(tag, 1'b1, d, 1'b0, 1'b0, 1'b0); endtask
   task automatic pop1(input string tag);  step(tag, 1'b0, '0, 1'b1, 1'b0, 1'b0); endtask
   task automatic idle(input string tag, input logic tick); step(tag, 1'b0, '0, 1'b0, tick, 1'b0); endtask

   initial begin
      logic [31:0] r;
      bus.push = 1'b0; bus.pop = 1'b0; bus.push_d = '0;
      #12;
      check_all("reset");
      @(negedge PCLK);
      PRESETn = 1'b1;
      idle("post_reset", 1'b0);

      for (int i = 0; i < 16; i++) push1("fill", EW'(i));
      for (int i = 0; i < 16; i++) pop1("drain");

      for (int i = 0; i < 16; i++) push1("fill2", EW'(i));
      push1("ovr", 11'h0AA);
      idle("ovr_fall", 1'b0);
      step("ovr_pop", 1'b1, 11'h0AA, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 16; i++) pop1("drain2");

      trigger_lvl = 2'd2;
      for (int i = 0; i < 8; i++) push1("trig", EW'(8'h30 + i));
      for (int i = 0; i < 4; i++) pop1("trig_pop");
      for (int i = 0; i < 40; i++) step("wrap", 1'b1, EW'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) pop1("wrap_drain");

      push1("err_fe", 11'h241);
      push1("err_clean", 11'h042);
      pop1("err_pop1");
      pop1("err_pop2");

      push1("to_push", 11'h055);
      for (int i = 0; i < 3; i++) idle("to_tick3", 1'b1);
      idle("to_tick4", 1'b1);
      idle("to_hold", 1'b1);
      pop1("to_pop");

      for (int i = 0; i < 5; i++) push1("m16450_fill", EW'(8'h60 + i));
      ena = 1'b0;
      idle("m16450_flush", 1'b0);
      push1("m16450_p1", 11'h011);
      push1("m16450_p2", 11'h022);
      step("m16450_ow_pop", 1'b1, 11'h433, 1'b1, 1'b0, 1'b0);
      step("clr_push", 1'b1, 11'h044, 1'b0, 1'b0, 1'b1);
      ena = 1'b1;
      idle("back_to_fifo", 1'b0);

      for (int i = 0; i < 600; i++) begin
         r = $urandom;
         if (r[31:25] == 7'd0) ena = ~ena;
         if (r[24:20] == 5'd0) trigger_lvl = r[19:18];
         step("rand", r[0] | r[1], {r[2] & r[3] ? r[6:4] : 3'b0, r[15:8]},
              r[16] & r[17], r[7], r[30:26] == 5'd0);
      end

      ena = 1'b1;
      idle("pre_arst", 1'b0);
      for (int i = 0; i < 3; i++) push1("pre_arst_fill", 11'h100 | EW'(i));
      #3;
      PRESETn = 1'b0;
      #1;
      q.delete(); tk = 0; ovr_m = 1'b0; ena_qm = 1'b0;
      check_all("async_rst");
      @(negedge PCLK);
      PRESETn = 1'b1;
      idle("arst_release", 1'b0);
      push1("arst_push", 11'h07E);
      pop1("arst_pop");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
